// File: rtl/body_rate_controller.sv
// body_rate_controller: per-axis rate PID (yaw/pitch/roll) with clamped integrators and saturated commands; in: us_clk, resetn, start_signal, throttle/yaw/pitch/roll targets, yaw/pitch/roll gyro rates; out: throttle/yaw/pitch/roll_cmd, active_signal, complete_signal
module body_rate_controller #(
  parameter int WIDTH = 16,
  parameter int K_P_PR = 3,
  parameter int K_I_PR = 1,
  parameter int K_D_PR = 2,
  parameter int K_P_Y = 4,
  parameter int GAIN_SHIFT = 2,
  parameter int I_LIMIT = 3200,
  parameter int OUT_LIMIT = 4000,
  parameter int IDLE_THROTTLE = 160
) (
  input  logic                    us_clk,
  input  logic                    resetn,
  input  logic                    start_signal,
  input  logic signed [WIDTH-1:0] throttle_rate_in,
  input  logic signed [WIDTH-1:0] yaw_rate_target,
  input  logic signed [WIDTH-1:0] pitch_rate_target,
  input  logic signed [WIDTH-1:0] roll_rate_target,
  input  logic signed [WIDTH-1:0] yaw_rate_actual,
  input  logic signed [WIDTH-1:0] pitch_rate_actual,
  input  logic signed [WIDTH-1:0] roll_rate_actual,
  output logic signed [WIDTH-1:0] throttle_cmd,
  output logic signed [WIDTH-1:0] yaw_cmd,
  output logic signed [WIDTH-1:0] pitch_cmd,
  output logic signed [WIDTH-1:0] roll_cmd,
  output logic                    active_signal,
  output logic                    complete_signal
);
  typedef enum logic [6:0] {
    WAITING  = 7'b0000001,
    LATCH    = 7'b0000010,
    ERROR    = 7'b0000100,
    TERMS    = 7'b0001000,
    SUM      = 7'b0010000,
    LIMIT    = 7'b0100000,
    COMPLETE = 7'b1000000
  } state_t;
  state_t state, state_n;
  logic start_q;
  logic idle;
  logic signed [WIDTH-1:0] thr;
  function automatic logic signed [31:0] gain(input logic signed [31:0] x, input int k);
    return (x * k) >>> GAIN_SHIFT;
  endfunction
  function automatic logic signed [31:0] clamp(input logic signed [31:0] x, input int lo, input int hi);
    return x < lo ? lo : x > hi ? hi : x;
  endfunction
  assign idle = 32'(thr) < IDLE_THROTTLE;
  always_ff @(posedge us_clk or negedge resetn) begin
    if (!resetn) begin
      state <= WAITING;
      start_q <= 1'b0;
      thr <= '0;
      throttle_cmd <= '0;
    end else begin
      state <= state_n;
      start_q <= start_signal;
      if (state == LATCH) thr <= throttle_rate_in;
      if (state == LIMIT) throttle_cmd <= WIDTH'(clamp(32'(thr), 0, OUT_LIMIT));
    end
  end
  always_comb begin
    state_n = WAITING;
    case (state)
      WAITING: state_n = (start_signal && !start_q) ? LATCH : WAITING;
      LATCH:   state_n = ERROR;
      ERROR:   state_n = TERMS;
      TERMS:   state_n = SUM;
      SUM:     state_n = LIMIT;
      LIMIT:   state_n = COMPLETE;
      default: state_n = WAITING;
    endcase
    active_signal = state == LATCH || state == ERROR || state == TERMS || state == SUM || state == LIMIT;
    complete_signal = state == COMPLETE;
  end
  for (genvar g = 0; g < 3; g++) begin : axis
    localparam int KP = g == 0 ? K_P_Y : K_P_PR;
    localparam int KI = g == 0 ? 0 : K_I_PR;
    localparam int KD = g == 0 ? 0 : K_D_PR;
    logic signed [WIDTH-1:0] tgt_in, act_in, tgt, act, err, prev, integ, i_new, cmd;
    logic signed [WIDTH:0] diff;
    logic signed [31:0] p, d, sum;
    assign tgt_in = g == 0 ? yaw_rate_target : g == 1 ? pitch_rate_target : roll_rate_target;
    assign act_in = g == 0 ? yaw_rate_actual : g == 1 ? pitch_rate_actual : roll_rate_actual;
    assign diff = {tgt[WIDTH-1], tgt} - {act[WIDTH-1], act};
    always_ff @(posedge us_clk or negedge resetn) begin
      if (!resetn) begin
        tgt <= '0;
        act <= '0;
        err <= '0;
        prev <= '0;
        integ <= '0;
        i_new <= '0;
        cmd <= '0;
        p <= '0;
        d <= '0;
        sum <= '0;
      end else if (state == LATCH) begin
        tgt <= tgt_in;
        act <= act_in;
      end else if (state == ERROR) begin
        err <= diff[WIDTH] != diff[WIDTH-1] ? {diff[WIDTH], {(WIDTH-1){~diff[WIDTH]}}} : diff[WIDTH-1:0];
      end else if (state == TERMS) begin
        p <= gain(32'(err), KP);
        i_new <= idle ? '0 : WIDTH'(clamp(32'(integ) + gain(32'(err), KI), -I_LIMIT, I_LIMIT));
        d <= gain(32'(err) - 32'(prev), KD);
      end else if (state == SUM) begin
        integ <= i_new;
        prev <= err;
        sum <= p + 32'(i_new) + d;
      end else if (state == LIMIT) begin
        cmd <= WIDTH'(clamp(sum, -OUT_LIMIT, OUT_LIMIT));
      end
    end
  end
  assign yaw_cmd = axis[0].cmd;
  assign pitch_cmd = axis[1].cmd;
  assign roll_cmd = axis[2].cmd;
endmodule

// File: tb/tb_body_rate_controller.sv
// tb_body_rate_controller: directed self-checking bench for body_rate_controller
module tb_body_rate_controller;
  logic us_clk = 1'b0;
  logic resetn = 1'b0;
  logic start_signal = 1'b0;
  logic signed [15:0] throttle_rate_in = '0;
  logic signed [15:0] yaw_rate_target = '0, pitch_rate_target = '0, roll_rate_target = '0;
  logic signed [15:0] yaw_rate_actual = '0, pitch_rate_actual = '0, roll_rate_actual = '0;
  logic signed [15:0] throttle_cmd, yaw_cmd, pitch_cmd, roll_cmd;
  logic active_signal, complete_signal;
  int passed = 0;
  int total = 0;
  body_rate_controller dut (
    .us_clk(us_clk),
    .resetn(resetn),
    .start_signal(start_signal),
    .throttle_rate_in(throttle_rate_in),
    .yaw_rate_target(yaw_rate_target),
    .pitch_rate_target(pitch_rate_target),
    .roll_rate_target(roll_rate_target),
    .yaw_rate_actual(yaw_rate_actual),
    .pitch_rate_actual(pitch_rate_actual),
    .roll_rate_actual(roll_rate_actual),
    .throttle_cmd(throttle_cmd),
    .yaw_cmd(yaw_cmd),
    .pitch_cmd(pitch_cmd),
    .roll_cmd(roll_cmd),
    .active_signal(active_signal),
    .complete_signal(complete_signal)
  );
  always #5 us_clk = ~us_clk;
  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask
  task automatic drive(input int th, yt, ya, pt, pa, rt, ra);
    throttle_rate_in = 16'(th);
    yaw_rate_target = 16'(yt);
    yaw_rate_actual = 16'(ya);
    pitch_rate_target = 16'(pt);
    pitch_rate_actual = 16'(pa);
    roll_rate_target = 16'(rt);
    roll_rate_actual = 16'(ra);
  endtask
  task automatic run(input string tag, input int th, yt, ya, pt, pa, rt, ra);
    int n;
    bit done;
    bit act1;
    @(negedge us_clk);
    drive(th, yt, ya, pt, pa, rt, ra);
    start_signal = 1'b1;
    n = 0;
    done = 1'b0;
    act1 = 1'b0;
    while (!done && n < 20) begin
      @(posedge us_clk);
      #1;
      n++;
      if (n == 1) act1 = active_signal;
      done = complete_signal;
    end
    chk({tag, ".latency"}, n, 6);
    chk({tag, ".active"}, int'(act1), 1);
    @(posedge us_clk);
    #1;
    chk({tag, ".pulse"}, int'(complete_signal), 0);
    @(negedge us_clk);
    start_signal = 1'b0;
    @(negedge us_clk);
  endtask
  initial begin
    int comps;
    int last;
    repeat (2) @(posedge us_clk);
    #1;
    chk("rst.pitch", pitch_cmd, 0);
    chk("rst.throttle", throttle_cmd, 0);
    chk("rst.active", int'(active_signal), 0);
    chk("rst.complete", int'(complete_signal), 0);
    @(negedge us_clk);
    resetn = 1'b1;
    run("u1", 800, 0, 0, 160, 0, 0, 0);
    chk("u1.pitch", pitch_cmd, 240);
    chk("u1.throttle", throttle_cmd, 800);
    chk("u1.yaw", yaw_cmd, 0);
    run("u2", 800, 0, 0, 160, 0, 0, 0);
    chk("u2.pitch", pitch_cmd, 200);
    for (int i = 0; i < 4; i++) begin
      run("roll", 800, 0, 0, 0, 0, 3200, -3200);
      chk("roll.cmd", roll_cmd, 4000);
      chk("roll.integ", dut.axis[2].integ, i == 0 ? 1600 : 3200);
    end
    @(negedge us_clk);
    resetn = 1'b0;
    @(negedge us_clk);
    resetn = 1'b1;
    run("acc1", 800, 0, 0, 160, 0, 0, 0);
    chk("acc1.pitch", pitch_cmd, 240);
    run("acc2", 800, 0, 0, 160, 0, 0, 0);
    chk("acc2.pitch", pitch_cmd, 200);
    run("acc3", 800, 0, 0, 160, 0, 0, 0);
    chk("acc3.pitch", pitch_cmd, 240);
    chk("acc3.integ", dut.axis[1].integ, 120);
    run("idle", 0, 0, 0, 160, 0, 0, 0);
    chk("idle.pitch", pitch_cmd, 120);
    chk("idle.throttle", throttle_cmd, 0);
    chk("idle.integ", dut.axis[1].integ, 0);
    run("yaw1", 5000, 400, 0, 0, 0, 0, 0);
    chk("yaw1.yaw", yaw_cmd, 400);
    chk("yaw1.throttle", throttle_cmd, 4000);
    chk("yaw1.pitch", pitch_cmd, -80);
    run("yaw2", 5000, 400, 0, 0, 0, 0, 0);
    chk("yaw2.yaw", yaw_cmd, 400);
    chk("yaw2.pitch", pitch_cmd, 0);
    run("pre", 800, 0, 0, 160, 0, 0, 0);
    chk("pre.pitch", pitch_cmd, 240);
    @(negedge us_clk);
    drive(800, 0, 0, 160, 0, 0, 0);
    start_signal = 1'b1;
    comps = 0;
    repeat (3) begin
      @(posedge us_clk);
      #1;
      if (complete_signal) comps++;
    end
    chk("abort.active", int'(active_signal), 1);
    @(negedge us_clk);
    resetn = 1'b0;
    #1;
    chk("abort.pitch", pitch_cmd, 0);
    chk("abort.active_rst", int'(active_signal), 0);
    @(negedge us_clk);
    resetn = 1'b1;
    last = -1;
    repeat (20) begin
      @(posedge us_clk);
      #1;
      if (complete_signal) begin
        comps++;
        last = pitch_cmd;
      end
    end
    chk("abort.completes", comps, 1);
    chk("abort.fresh_pitch", last, 240);
    chk("abort.integ", dut.axis[1].integ, 40);
    @(negedge us_clk);
    start_signal = 1'b0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
